mips_if_prefetch: RTL
=====================

MIPS_IF_PREFETCH -- requirements
Module: mips_if_prefetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning prefetch queue entries (power of two, 2..32).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0, meaning fetch address after reset.
REQ-003 The block SHALL have one clock and asynchronous active-high reset: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous reset, active-high.
REQ-005 redirect  input  1  branch/jump taken; flush queue and refetch.
REQ-006 redirect_addr  input  32  redirect target; bits [1:0] ignored.
REQ-007 I_read  output  1  I-cache read request.
REQ-008 I_write  output  1  tied 0.
REQ-009 I_addr  output  30  word address of current fetch.
REQ-010 I_wdata  output  32  tied 0.
REQ-011 I_stall  input  1  I-cache busy; I_rdata is valid in any cycle with I_read=1 and I_stall=0.
REQ-012 I_rdata  input  32  fetched instruction.
REQ-013 ID_ready  input  1  decode accepts the head entry this cycle.
REQ-014 ID_valid  output  1  head entry valid.
REQ-015 ID_pc  output  32  byte PC of head entry.
REQ-016 ID_inst  output  32  instruction of head entry.
REQ-017 IF_stall  output  1  queue empty and fetch not completing (I_stall=1 or FLUSH_WAIT).
REQ-018 count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-019 The block SHALL keep a fetch PC fpc; I_addr SHALL equal fpc[31:2] in every cycle.
REQ-020 In state RUN, I_read SHALL be 1 iff count<DEPTH; it SHALL NOT depend combinationally on ID_ready.
REQ-021 A fetch completes in a cycle with I_read=1, I_stall=0, redirect=0: push {fpc, I_rdata} at tail, fpc <= fpc+4 (modulo 2^32).
REQ-022 With I_read=1 and I_stall=1, fpc and I_addr SHALL hold unchanged.
REQ-023 ID_valid SHALL be (count!=0); ID_pc/ID_inst SHALL show head entry, and SHALL be 0/0 (bubble) when empty.
REQ-024 Pop SHALL occur when ID_valid=1 and ID_ready=1 and redirect=0; head advances next cycle.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; head/tail pointers wrap modulo DEPTH.
REQ-026 Push is impossible when count=DEPTH (I_read=0); pop at count=0 SHALL be ignored.
REQ-027 Fetch-to-ID latency SHALL be 1 cycle: data captured at edge N appears on ID_* after edge N.
REQ-028 redirect=1 SHALL flush the queue (count=0 next cycle); a coincident push and pop SHALL be discarded.
REQ-029 redirect in RUN with no access in progress (I_read=0 or I_stall=0): fpc <= {redirect_addr[31:2],2'b00}, stay RUN.
REQ-030 redirect in RUN with I_read=1 and I_stall=1: save target, go to FLUSH_WAIT; I_read and I_addr SHALL hold until I_stall=0.
REQ-031 In FLUSH_WAIT: when I_stall=0, returned data SHALL be discarded, fpc <= saved target, state RUN; no push SHALL occur in FLUSH_WAIT.
REQ-032 A redirect during FLUSH_WAIT SHALL overwrite the saved target (latest wins) and flush the queue.
REQ-033 States SHALL be exactly RUN and FLUSH_WAIT; no other transitions exist.

Reset
REQ-034 While rst=1, and immediately on its assertion regardless of clock: fpc=RESET_PC, count=0, pointers=0, state=RUN, saved target=0.
REQ-035 While rst=1, I_read=0, ID_valid=0, ID_pc=0, ID_inst=0, IF_stall=0; after deassertion, I_read follows REQ-020.
REQ-036 Reset asserted during an outstanding stalled fetch SHALL abandon it; no data from it SHALL enter the queue.

Verification (DEPTH=4, RESET_PC=0)
REQ-037 Fill: release rst, I_stall=0, ID_ready=0 -> pushes PCs 0,4,8,12 in 4 cycles, count=4, I_read=0, I_addr=0x4, ID_pc=0 held.
REQ-038 Stream: ID_ready=1, I_stall=0 -> one pop per cycle, ID_pc = 0,4,8,... starting one cycle after first fetch, count steady at 1.
REQ-039 Fast redirect: redirect=1, redirect_addr=0x103, I_stall=0 -> next cycle count=0, ID_valid=0, I_addr=0x40; cycle after, ID_pc=0x100.
REQ-040 Stalled redirect: I_stall=1 at I_addr=0x10, redirect to 0x200, stall 3 more cycles -> I_addr stays 0x10, no push, then I_addr=0x80 and first entry ID_pc=0x200.
REQ-041 Double redirect: in FLUSH_WAIT, redirect to 0x300 -> after I_stall=0, I_addr=0xC0; 0x200 never fetched.
REQ-042 Mid-operation reset: rst pulsed with count=3 and I_stall=1 -> count=0, ID_valid=0 immediately; after release, first ID_pc=0.

Source files
------------

// File: rtl/mips_if_prefetch.sv
// MIPS instruction-fetch stage with a small prefetch queue.
// A fetch PC walks the I-cache one word at a time while the queue has room;
// decode drains the queue from the head. A redirect flushes the queue and
// restarts fetch at the new target. When a redirect lands on a stalled
// I-cache access, the access is allowed to finish (its data is thrown away)
// in FLUSH_WAIT before fetch moves to the saved target.
module mips_if_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [31:0]              redirect_addr,
    output logic                     I_read,
    output logic                     I_write,
    output logic [29:0]              I_addr,
    output logic [31:0]              I_wdata,
    input  logic                     I_stall,
    input  logic [31:0]              I_rdata,
    input  logic                     ID_ready,
    output logic                     ID_valid,
    output logic [31:0]              ID_pc,
    output logic [31:0]              ID_inst,
    output logic                     IF_stall,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] ST_RUN        = 1'b0;
    localparam logic [0:0] ST_FLUSH_WAIT = 1'b1;

    // Fetch PC and saved target are kept as word addresses; the byte-offset
    // bits are always zero and are re-appended where a byte PC is needed.
    logic [0:0]    r_state;
    logic [29:0]   r_fpc;
    logic [29:0]   r_target;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [29:0]   w_entry_pc   [DEPTH];
    logic [31:0]   w_entry_inst [DEPTH];

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_access_stalled;
    logic [29:0]   w_redir_word;
    logic [29:0]   w_head_pc;
    logic [31:0]   w_head_inst;
    logic [1:0]    w_unused_addr_bits;

    assign w_redir_word       = redirect_addr[31:2];
    assign w_unused_addr_bits = redirect_addr[1:0];

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // I_read is a function of registered state only (plus reset gating), so
    // decode's ready never reaches the I-cache request combinationally.
    assign I_read  = ~rst & ((r_state == ST_FLUSH_WAIT) | ~w_full);
    assign I_write = 1'b0;
    assign I_wdata = 32'h0;
    assign I_addr  = r_fpc;

    assign w_access_stalled = I_read & I_stall;

    // Pushes only happen in RUN; data returned in FLUSH_WAIT belongs to the
    // abandoned path. A redirect discards anything arriving this cycle.
    assign w_push = (r_state == ST_RUN) & I_read & ~I_stall & ~redirect;
    assign w_pop  = ~w_empty & ID_ready & ~redirect;

    assign w_head_pc   = w_entry_pc[r_head];
    assign w_head_inst = w_entry_inst[r_head];

    assign ID_valid = ~w_empty;
    assign ID_pc    = w_empty ? 32'h0 : {w_head_pc, 2'b00};
    assign ID_inst  = w_empty ? 32'h0 : w_head_inst;
    assign count    = r_count;

    // Decode starves when nothing is queued and no fetch is landing this cycle.
    assign IF_stall = ~rst & w_empty & ((r_state == ST_FLUSH_WAIT) | I_stall);

    // Queue storage: one register pair per entry, written when the tail
    // points at it. The head is read combinationally so a captured entry is
    // visible to decode right after the capturing edge.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [29:0] r_pc;
            logic [31:0] r_inst;

            // Capture fetched PC/instruction into this slot on a push.
            always_ff @(posedge clk) begin
                if (w_push && (r_tail == PW'(gi))) begin
                    r_pc   <= r_fpc;
                    r_inst <= I_rdata;
                end
            end

            assign w_entry_pc[gi]   = r_pc;
            assign w_entry_inst[gi] = r_inst;
        end
    endgenerate

    // Fetch control: fpc stepping, redirect handling and the RUN/FLUSH_WAIT FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_fpc    <= RESET_PC[31:2];
            r_target <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (redirect) begin
                        if (w_access_stalled) begin
                            // Access in flight: keep I_addr stable until the
                            // cache releases, then jump.
                            r_target <= w_redir_word;
                            r_state  <= ST_FLUSH_WAIT;
                        end else begin
                            r_fpc <= w_redir_word;
                        end
                    end else if (w_push) begin
                        r_fpc <= r_fpc + 30'd1;
                    end
                end
                ST_FLUSH_WAIT: begin
                    if (redirect) begin
                        r_target <= w_redir_word;
                    end
                    if (!I_stall) begin
                        // Latest redirect wins even if it arrives on the
                        // very cycle the stalled access completes.
                        r_fpc   <= redirect ? w_redir_word : r_target;
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (redirect) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule
